// File: rtl/carrier_update_sched.sv
// carrier_update_sched: shadow/active config scheduler for the PWM carrier bank, atomic commit now or at master zero crossing.
// Optional `CARR_SYNC_TIMEOUT_EN`: bounds the boundary wait to TIMEOUT cycles and raises a sticky timeout flag.
module carrier_update_sched #(
  parameter int NCH     = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [CW-1:0]     cfg_period,
  input  logic [CW-1:0]     cfg_init,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_on,
  input  logic              commit,
  input  logic              sync_mode,
  input  logic [CW-1:0]     carrier_ref,
  output logic [NCH*CW-1:0] period_o,
  output logic [NCH*CW-1:0] init_o,
  output logic [NCH*2-1:0]  mode_o,
  output logic [NCH-1:0]    on_o,
  output logic [NCH-1:0]    load_o,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_APPLY} state_t;

  state_t                   state_q, state_d;
  logic [NCH-1:0][CW-1:0]   sh_period_q, sh_init_q, act_period_q, act_init_q;
  logic [NCH-1:0][1:0]      sh_mode_q, act_mode_q;
  logic [NCH-1:0]           sh_on_q, act_on_q, pending_q, load_q, wr_sel;
  logic [CW-1:0]            ref_q;
  logic                     done_q, err_q, ch_valid, wr_ok, boundary, tmo_hit;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) wr_sel[i] = (cfg_ch == 3'(i));
  end

  assign ch_valid = |wr_sel;
  assign wr_ok    = cfg_wr && (state_q == S_IDLE) && ch_valid;
  // A stopped or unconfigured master has no zero crossing to wait for.
  assign boundary = ((carrier_ref == '0) && (ref_q != '0)) || (act_mode_q[0] == 2'd0) ||
                    (act_period_q[0] == '0) || !act_on_q[0];

`ifdef CARR_SYNC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wait_q;
  logic          timeout_q;

  assign tmo_hit = (state_q == S_ARMED) && !boundary && (wait_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q <= (state_q == S_ARMED) ? wait_q + 1'b1 : '0;
      if (tmo_hit) timeout_q <= 1'b1;
      else if (commit && state_q == S_IDLE) timeout_q <= 1'b0;
    end
  end
  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (commit) state_d = sync_mode ? S_ARMED : S_APPLY;
      S_ARMED: if (boundary || tmo_hit) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_period_q  <= '0;
      sh_init_q    <= '0;
      sh_mode_q    <= '0;
      sh_on_q      <= '0;
      pending_q    <= '0;
      act_period_q <= '0;
      act_init_q   <= '0;
      act_mode_q   <= '0;
      act_on_q     <= '0;
      load_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ref_q        <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok && wr_sel[i]) begin
          sh_period_q[i] <= cfg_period;
          sh_init_q[i]   <= cfg_init;
          sh_mode_q[i]   <= cfg_mode;
          sh_on_q[i]     <= cfg_on;
          pending_q[i]   <= 1'b1;
        end
        if (state_q == S_APPLY && pending_q[i]) begin
          act_period_q[i] <= sh_period_q[i];
          act_init_q[i]   <= sh_init_q[i];
          act_mode_q[i]   <= sh_mode_q[i];
          act_on_q[i]     <= sh_on_q[i];
        end
      end
      if (state_q == S_APPLY) pending_q <= '0;
      load_q <= (state_q == S_APPLY) ? pending_q : '0;
      done_q <= (state_q == S_APPLY);
      err_q  <= cfg_wr && !((state_q == S_IDLE) && ch_valid);
      ref_q  <= carrier_ref;
    end
  end

  assign period_o = act_period_q;
  assign init_o   = act_init_q;
  assign mode_o   = act_mode_q;
  assign on_o     = act_on_q;
  assign load_o   = load_q;
  assign done     = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_carrier_update_sched.sv
// Directed bench for carrier_update_sched: table of single-cycle vectors plus hand sequences for sync, reset and timeout.
module tb_carrier_update_sched;
  localparam int NCH = 6;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_wr;
  logic [2:0]        cfg_ch;
  logic [CW-1:0]     cfg_period, cfg_init;
  logic [1:0]        cfg_mode;
  logic              cfg_on, commit, sync_mode;
  logic [CW-1:0]     carrier_ref;
  logic [NCH*CW-1:0] period_o, init_o;
  logic [NCH*2-1:0]  mode_o;
  logic [NCH-1:0]    on_o, load_o;
  logic              busy, done, cfg_err, timeout;

  always #5 clk = ~clk;

  carrier_update_sched #(.NCH(NCH), .CW(CW), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_init(cfg_init), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .commit(commit),
    .sync_mode(sync_mode), .carrier_ref(carrier_ref), .period_o(period_o), .init_o(init_o),
    .mode_o(mode_o), .on_o(on_o), .load_o(load_o), .busy(busy), .done(done),
    .cfg_err(cfg_err), .timeout(timeout)
  );

  typedef struct {
    logic wr; logic [2:0] ch; logic [15:0] p; logic [15:0] i; logic [1:0] m; logic on; logic cm;
    logic [2:0] xch; logic [15:0] xp; logic [15:0] xi; logic [1:0] xm; logic xon;
    logic [NCH-1:0] xload; logic xbusy; logic xdone; logic xerr;
  } vec_t;

  vec_t tbl[9];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_wr = 1'b0; commit = 1'b0; sync_mode = 1'b0;
  endtask

  task automatic drive_wr(input logic [2:0] ch, input logic [15:0] p, input logic [15:0] i,
                          input logic [1:0] m, input logic on);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_period = p; cfg_init = i; cfg_mode = m; cfg_on = on;
  endtask

  function automatic logic [15:0] per(input int ch);
    return period_o[ch*CW +: CW];
  endfunction

  function automatic vec_t mk(input logic wr, input logic [2:0] ch, input logic [15:0] p,
      input logic [15:0] i, input logic [1:0] m, input logic on, input logic cm,
      input logic [2:0] xch, input logic [15:0] xp, input logic [15:0] xi, input logic [1:0] xm,
      input logic xon, input logic [NCH-1:0] xload, input logic xbusy, input logic xdone,
      input logic xerr);
    vec_t v;
    v.wr = wr; v.ch = ch; v.p = p; v.i = i; v.m = m; v.on = on; v.cm = cm;
    v.xch = xch; v.xp = xp; v.xi = xi; v.xm = xm; v.xon = xon;
    v.xload = xload; v.xbusy = xbusy; v.xdone = xdone; v.xerr = xerr;
    return v;
  endfunction

  initial begin
    //           wr ch  p    i   m  on cm  xch xp   xi  xm xon xload      busy done err
    tbl[0] = mk(0, 0, 0,   0,  0, 0, 0,  0, 0,   0,  0, 0, 6'b000000, 0, 0, 0);
    tbl[1] = mk(1, 7, 5,   5,  1, 1, 0,  0, 0,   0,  0, 0, 6'b000000, 0, 0, 1);
    tbl[2] = mk(1, 2, 100, 50, 3, 1, 0,  2, 0,   0,  0, 0, 6'b000000, 0, 0, 0);
    tbl[3] = mk(0, 0, 0,   0,  0, 0, 1,  2, 0,   0,  0, 0, 6'b000000, 1, 0, 0);
    tbl[4] = mk(0, 0, 0,   0,  0, 0, 0,  2, 100, 50, 3, 1, 6'b000100, 0, 1, 0);
    tbl[5] = mk(0, 0, 0,   0,  0, 0, 0,  0, 0,   0,  0, 0, 6'b000000, 0, 0, 0);
    tbl[6] = mk(1, 4, 33,  1,  2, 1, 1,  4, 0,   0,  0, 0, 6'b000000, 1, 0, 0);
    tbl[7] = mk(0, 0, 0,   0,  0, 0, 0,  4, 33,  1,  2, 1, 6'b010000, 0, 1, 0);
    tbl[8] = mk(0, 0, 0,   0,  0, 0, 0,  2, 100, 50, 3, 1, 6'b000000, 0, 0, 0);

    reset = 1'b1; idle_in(); cfg_ch = '0; cfg_period = '0; cfg_init = '0;
    cfg_mode = '0; cfg_on = 1'b0; carrier_ref = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_period", 32'(period_o == '0), 32'd1);
    chk("rst_mode",   32'(mode_o), 32'd0);
    chk("rst_on",     32'(on_o), 32'd0);
    chk("rst_load",   32'(load_o), 32'd0);
    chk("rst_flags",  {28'd0, busy, done, cfg_err, timeout}, 32'd0);

    // Immediate commits, invalid channel, same-cycle write+commit.
    for (int r = 0; r < 9; r++) begin
      idle_in();
      if (tbl[r].wr) drive_wr(tbl[r].ch, tbl[r].p, tbl[r].i, tbl[r].m, tbl[r].on);
      commit = tbl[r].cm;
      step();
      chk($sformatf("v%0d_busy", r), 32'(busy), 32'(tbl[r].xbusy));
      chk($sformatf("v%0d_done", r), 32'(done), 32'(tbl[r].xdone));
      chk($sformatf("v%0d_err", r),  32'(cfg_err), 32'(tbl[r].xerr));
      chk($sformatf("v%0d_load", r), 32'(load_o), 32'(tbl[r].xload));
      chk($sformatf("v%0d_per", r),  32'(per(int'(tbl[r].xch))), 32'(tbl[r].xp));
      chk($sformatf("v%0d_init", r), 32'(init_o[tbl[r].xch*CW +: CW]), 32'(tbl[r].xi));
      chk($sformatf("v%0d_mode", r), 32'(mode_o[tbl[r].xch*2 +: 2]), 32'(tbl[r].xm));
      chk($sformatf("v%0d_on", r),   32'(on_o[tbl[r].xch]), 32'(tbl[r].xon));
      chk($sformatf("v%0d_tmo", r),  32'(timeout), 32'd0);
    end
    idle_in();

    // Master running COUNT_UP period 10; sync commit waits for the 9->0 wrap.
    carrier_ref = 16'd3;
    drive_wr(0, 10, 0, 1, 1); commit = 1'b1;
    step(); idle_in(); step();
    chk("master_mode", 32'(mode_o[1:0]), 32'd1);
    drive_wr(1, 200, 20, 2, 1); step();
    drive_wr(5, 300, 30, 3, 0); step();
    idle_in(); commit = 1'b1; sync_mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      idle_in();
      carrier_ref = 16'((3 + k) % 10);
      if (k <= 8) begin
        chk($sformatf("sync_busy_k%0d", k), 32'(busy), 32'd1);
        chk($sformatf("sync_done_k%0d", k), 32'(done), 32'd0);
      end
      if (k == 3) chk("armed_wr_err", 32'(cfg_err), 32'd1);
      if (k == 9) begin
        chk("sync_done", 32'(done), 32'd1);
        chk("sync_load", 32'(load_o), 32'(6'b100010));
        chk("sync_busy_end", 32'(busy), 32'd0);
        chk("sync_per1", 32'(per(1)), 32'd200);
        chk("sync_per5", 32'(per(5)), 32'd300);
        chk("sync_on5",  32'(on_o[5]), 32'd0);
        chk("sync_mode5", 32'(mode_o[11:10]), 32'd3);
        chk("armed_ch3_unchanged", 32'(per(3)), 32'd0);
      end
      if (k == 2) drive_wr(3, 77, 7, 1, 1);
    end
    step();
    chk("sync_done_clr", 32'(done), 32'd0);

    // Reset while ARMED discards the pending write and the commit.
    carrier_ref = 16'd5;
    drive_wr(2, 999, 9, 1, 1); step();
    idle_in(); commit = 1'b1; sync_mode = 1'b1; step();
    idle_in(); step(); step();
    chk("armed_hold", 32'(busy), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstarm_busy", 32'(busy), 32'd0);
    chk("rstarm_active", 32'(period_o == '0 && mode_o == '0 && on_o == '0), 32'd1);
    step();
    chk("rstarm_nodone", 32'(done), 32'd0);
    commit = 1'b1; step(); idle_in(); step();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_load", 32'(load_o), 32'd0);
    chk("empty_per2", 32'(per(2)), 32'd0);

`ifdef CARR_SYNC_TIMEOUT_EN
    // Master running but carrier_ref stuck: the wait expires after 20 ARMED cycles.
    carrier_ref = 16'd7;
    drive_wr(0, 10, 0, 1, 1); commit = 1'b1;
    step(); idle_in(); step(); step();
    commit = 1'b1; sync_mode = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      idle_in();
      if (k <= 21) chk($sformatf("tmo_busy_k%0d", k), 32'(busy), 32'd1);
      if (k == 20) chk("tmo_not_yet", 32'(timeout), 32'd0);
      if (k == 21) chk("tmo_set", 32'(timeout), 32'd1);
      if (k == 21) chk("tmo_done_early", 32'(done), 32'd0);
      if (k == 22) begin
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_sticky", 32'(timeout), 32'd1);
        chk("tmo_busy_end", 32'(busy), 32'd0);
      end
    end
    step();
    chk("tmo_sticky2", 32'(timeout), 32'd1);
    commit = 1'b1; step(); idle_in();
    chk("tmo_clear", 32'(timeout), 32'd0);
    step(); step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
